// File: rtl/chop_pwm_generator_if.sv
// Bundles the run/config inputs and the chopping outputs of chop_pwm_generator.
// Latency: none, wires only.
// Backpressure: none; consumers sample the strobes on the clock they are high.
interface chop_pwm_generator_if #(
    parameter int CNT_W   = 24,
    parameter int BLANK_W = 16,
    parameter int DIV_W   = 16,
    parameter int CYC_W   = 16
) ();
    logic               enable;
    logic [CNT_W-1:0]   half_period;
    logic [BLANK_W-1:0] blank_cycles;
    logic [DIV_W-1:0]   sample_div;
    logic               switch_pwm;
    logic               acq_window;
    logic               sample_req;
    logic               sample_phase;
    logic               cycle_done;
    logic [DIV_W-1:0]   samples_per_half;
    logic [CYC_W-1:0]   cycle_count;
    logic               busy;

    // Controller side: drives run request and settings, observes the chopper.
    modport master (
        output enable, half_period, blank_cycles, sample_div,
        input  switch_pwm, acq_window, sample_req, sample_phase,
               cycle_done, samples_per_half, cycle_count, busy
    );

    // Generator side.
    modport slave (
        input  enable, half_period, blank_cycles, sample_div,
        output switch_pwm, acq_window, sample_req, sample_phase,
               cycle_done, samples_per_half, cycle_count, busy
    );
endinterface

// File: rtl/chop_pwm_generator.sv
// Chopping square wave with settle-blanking, phase-tagged sample strobes and cycle boundary pulse.
// Latency: outputs registered, one clock behind the FSM state; switch_pwm rises one clock after the start edge.
// Backpressure: none; a started cycle always runs to the end of its off half before enable is re-examined.
module chop_pwm_generator #(
    parameter int CNT_W   = 24,
    parameter int BLANK_W = 16,   // assumed <= CNT_W
    parameter int DIV_W   = 16,   // assumed <= CNT_W
    parameter int CYC_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    chop_pwm_generator_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ON_BLANK, S_ON_ACQ, S_OFF_BLANK, S_OFF_ACQ
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d;       // latched half period
    logic [CNT_W-1:0]   b_q, b_d;       // latched blank length
    logic [DIV_W-1:0]   d_q, d_d;       // latched sample divider
    logic [CNT_W-1:0]   cnt_q, cnt_d;   // clocks spent in current sub-state
    logic [DIV_W-1:0]   div_q, div_d;   // position inside sample divider
    logic               pwm_q, pwm_d;
    logic               acq_q, acq_d;
    logic               req_q, req_d;
    logic               phase_q, phase_d;
    logic               done_q, done_d;
    logic [DIV_W-1:0]   sph_q, sph_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               busy_q, busy_d;

    logic [BLANK_W-1:0] blank_in;
    logic [CNT_W-1:0]   h_in, b_ext, b_in, acq_len, n_req;
    logic [DIV_W-1:0]   d_in;
    logic               start, is_on, is_acq, acq_last;

    assign blank_in = bus.blank_cycles;

    // Clamp the live settings so every latched cycle has at least one acquire clock.
    always_comb begin
        h_in  = (bus.half_period < CNT_W'(2)) ? CNT_W'(2) : bus.half_period;
        b_ext = CNT_W'(blank_in);
        b_in  = (b_ext > h_in - CNT_W'(1)) ? h_in - CNT_W'(1) : b_ext;
        d_in  = (bus.sample_div == '0) ? DIV_W'(1) : bus.sample_div;
    end

    // Sequencing: half-cycle timing, sub-state counters and the config latch.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        b_d      = b_q;
        d_d      = d_q;
        cnt_d    = cnt_q + CNT_W'(1);
        div_d    = (div_q == d_q - DIV_W'(1)) ? '0 : div_q + DIV_W'(1);
        start    = 1'b0;
        acq_len  = h_q - b_q;
        acq_last = (cnt_q == acq_len - CNT_W'(1));
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                div_d = '0;
                start = bus.enable;
            end
            S_ON_BLANK, S_OFF_BLANK: begin
                if (cnt_q == b_q - CNT_W'(1)) begin
                    state_d = (state_q == S_ON_BLANK) ? S_ON_ACQ : S_OFF_ACQ;
                    cnt_d   = '0;
                    div_d   = '0;
                end
            end
            S_ON_ACQ: begin
                if (acq_last) begin
                    state_d = (b_q == '0) ? S_OFF_ACQ : S_OFF_BLANK;
                    cnt_d   = '0;
                    div_d   = '0;
                end
            end
            S_OFF_ACQ: begin
                if (acq_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    div_d   = '0;
                    start   = bus.enable;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new cycle always re-latches settings; zero blank goes straight to acquire.
        if (start) begin
            h_d     = h_in;
            b_d     = b_in;
            d_d     = d_in;
            state_d = (b_in == '0) ? S_ON_ACQ : S_ON_BLANK;
            cnt_d   = '0;
            div_d   = '0;
        end
    end

    // Output decode from the current state, registered below.
    always_comb begin
        is_on   = (state_q == S_ON_BLANK) || (state_q == S_ON_ACQ);
        is_acq  = (state_q == S_ON_ACQ) || (state_q == S_OFF_ACQ);
        pwm_d   = is_on;
        acq_d   = is_acq;
        req_d   = is_acq && (div_q == '0);
        phase_d = is_on;
        done_d  = (state_q == S_OFF_ACQ) && acq_last;
        cyc_d   = cyc_q + CYC_W'(done_d);
        busy_d  = (state_q != S_IDLE);
        // ceil(acq_len / D) written as (acq_len-1)/D + 1; acq_len >= 1 and D >= 1 outside IDLE.
        n_req   = ((acq_len - CNT_W'(1)) / ((d_q == '0) ? CNT_W'(1) : CNT_W'(d_q))) + CNT_W'(1);
        sph_d   = sph_q;
        if (state_q != S_IDLE) begin
            sph_d = (n_req > CNT_W'({DIV_W{1'b1}})) ? {DIV_W{1'b1}} : DIV_W'(n_req);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            pwm_q   <= 1'b0;
            acq_q   <= 1'b0;
            req_q   <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            sph_q   <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pwm_q   <= pwm_d;
            acq_q   <= acq_d;
            req_q   <= req_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            sph_q   <= sph_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.switch_pwm       = pwm_q;
    assign bus.acq_window       = acq_q;
    assign bus.sample_req       = req_q;
    assign bus.sample_phase     = phase_q;
    assign bus.cycle_done       = done_q;
    assign bus.samples_per_half = sph_q;
    assign bus.cycle_count      = cyc_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_chop_pwm_generator.sv
// Directed bench for chop_pwm_generator: table of steady-run configs plus hand sequences.
// Latency: outputs sampled on the falling edge, half a clock after each update.
// Backpressure: not applicable; every wait is bounded.
module tb_chop_pwm_generator;
    localparam int CNT_W   = 24;
    localparam int BLANK_W = 16;
    localparam int DIV_W   = 16;
    localparam int CYC_W   = 2;   // narrow so the wrap is reached quickly

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chop_pwm_generator_if #(.CNT_W(CNT_W), .BLANK_W(BLANK_W), .DIV_W(DIV_W), .CYC_W(CYC_W)) bus ();

    chop_pwm_generator #(.CNT_W(CNT_W), .BLANK_W(BLANK_W), .DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int h; int b; int d;          // raw inputs
        int ncyc;                     // cycles to run
        int exp_half;                 // clocks per half after clamping
        int exp_blank;                // blank clocks per half
        int exp_req;                  // requests per half
        int d_eff;                    // clamped divider
        int exp_sph;                  // samples_per_half
        bit exp_coin;                 // request on the cycle_done clock
    } vec_t;

    vec_t vecs[4];
    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_cfg(input int h, input int b, input int d);
        bus.half_period  = CNT_W'(h);
        bus.blank_cycles = BLANK_W'(b);
        bus.sample_div   = DIV_W'(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, int'({bus.switch_pwm, bus.acq_window, bus.sample_req,
                                     bus.sample_phase, bus.cycle_done, bus.busy}), 0);
        check({tag, "_sph"}, int'(bus.samples_per_half), 0);
        check({tag, "_cyc"}, int'(bus.cycle_count), 0);
    endtask

    // Observe one full cycle from its first high clock to its cycle_done clock.
    // hook_at > 0 rewrites enable/half_period on that clock of the on half.
    task automatic run_cycle(input vec_t v, input int exp_cyc, input int hook_at,
                             input bit hook_en, input int hook_h);
        int guard, bad, aidx, n, nb, nr;
        int cnt[2], blk[2], rq[2];
        bit stop, done_seen, coin;
        guard = 0; bad = 0; stop = 0; done_seen = 0; coin = 0;
        @(negedge clk);
        while (!bus.switch_pwm && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            check("align_timeout", 0, 1);
            return;
        end
        for (int half = 0; half < 2; half++) begin
            n = 0; nb = 0; nr = 0; aidx = 0;
            while ((bus.switch_pwm == (half == 0)) && n < 1000 && !stop) begin
                n++;
                if (!bus.acq_window) nb++;
                else begin
                    if (bus.sample_req && (aidx % v.d_eff) != 0) bad++;
                    aidx++;
                end
                if (bus.sample_req) nr++;
                if (bus.sample_phase != bus.switch_pwm) bad++;
                if (bus.cycle_done) begin
                    if (half == 0) bad++;
                    else begin
                        done_seen = 1'b1;
                        coin      = bus.sample_req;
                        stop      = 1'b1;
                    end
                end
                if (half == 0 && hook_at > 0 && n == hook_at) begin
                    bus.enable      = hook_en;
                    bus.half_period = CNT_W'(hook_h);
                end
                if (!stop) @(negedge clk);
            end
            cnt[half] = n; blk[half] = nb; rq[half] = nr;
        end
        check("on_clocks",   cnt[0], v.exp_half);
        check("off_clocks",  cnt[1], v.exp_half);
        check("on_blank",    blk[0], v.exp_blank);
        check("off_blank",   blk[1], v.exp_blank);
        check("on_reqs",     rq[0],  v.exp_req);
        check("off_reqs",    rq[1],  v.exp_req);
        check("grid_phase",  bad,    0);
        check("done_seen",   int'(done_seen), 1);
        check("coincide",    int'(coin), int'(v.exp_coin));
        check("spl_per_half", int'(bus.samples_per_half), v.exp_sph);
        check("cycle_count", int'(bus.cycle_count), exp_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int g;
        reset = 1'b1;
        bus.enable = 1'b0;
        set_cfg(10, 3, 2);

        //         h   b  d  ncyc half blank req deff sph coin
        vecs[0] = '{10, 3, 2, 3,   10,  3,   4,  2,   4,  1'b1};  // nominal
        vecs[1] = '{1,  9, 0, 2,   2,   1,   1,  1,   1,  1'b1};  // all clamps
        vecs[2] = '{6,  0, 4, 2,   6,   0,   2,  4,   2,  1'b0};  // no blank
        vecs[3] = '{4,  0, 3, 5,   4,   0,   2,  3,   2,  1'b1};  // wrap + coincident

        do_reset();
        check_all_zero("reset");

        foreach (vecs[i]) begin
            do_reset();
            set_cfg(vecs[i].h, vecs[i].b, vecs[i].d);
            bus.enable = 1'b1;
            for (int c = 0; c < vecs[i].ncyc; c++)
                run_cycle(vecs[i], (c + 1) % 4, 0, 1'b0, 0);
            bus.enable = 1'b0;
        end

        // Drop enable on clock 5 of the on half: cycle completes, then idle.
        do_reset();
        set_cfg(10, 3, 2);
        bus.enable = 1'b1;
        run_cycle(vecs[0], 1, 5, 1'b0, 10);
        @(negedge clk);
        check("dis_busy", int'(bus.busy), 0);
        check("dis_pwm",  int'(bus.switch_pwm), 0);
        repeat (5) @(negedge clk);
        check("dis_idle", int'({bus.busy, bus.switch_pwm, bus.cycle_done}), 0);
        check("dis_cyc",  int'(bus.cycle_count), 1);

        // Half period changed on clock 3: current cycle keeps 8, next uses 4.
        do_reset();
        set_cfg(8, 2, 3);
        bus.enable = 1'b1;
        v = '{8, 2, 3, 1, 8, 2, 2, 3, 2, 1'b0};
        run_cycle(v, 1, 3, 1'b1, 4);
        v = '{4, 2, 3, 1, 4, 2, 1, 3, 1, 1'b0};
        run_cycle(v, 2, 0, 1'b0, 0);
        bus.enable = 1'b0;

        // Start latency, then reset while in the on acquire window.
        do_reset();
        set_cfg(10, 3, 2);
        bus.enable = 1'b1;
        @(negedge clk);
        check("lat_pwm_k",  int'(bus.switch_pwm), 0);
        check("lat_busy_k", int'(bus.busy), 0);
        @(negedge clk);
        check("lat_pwm_k1",  int'(bus.switch_pwm), 1);
        check("lat_busy_k1", int'(bus.busy), 1);
        check("lat_sph_k1",  int'(bus.samples_per_half), 4);
        g = 0;
        while (!(bus.acq_window && bus.switch_pwm) && g < 50) begin
            g++;
            @(negedge clk);
        end
        check("reach_on_acq", int'(bus.acq_window && bus.switch_pwm), 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        run_cycle(vecs[0], 1, 0, 1'b0, 0);
        bus.enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/chop_pwm_generator.md
Name: chop_pwm_generator

Overview:
- Generates the emitter chopping signal `switch_pwm` that the ADC demodulation path consumes. It is the transmit side of the switch-on/switch-off lock-in scheme.
- Produces a square wave with programmable half-period.
- Marks a settling-blank window after each edge. Issues phase-tagged sample requests only inside the settled window.
- Pulses a cycle boundary so the demodulator can close on/off accumulations over matched sample counts.

Parameters:
- CNT_W, 24, width of half-period counter and `half_period` input
- BLANK_W, 16, width of `blank_cycles` input
- DIV_W, 16, width of `sample_div` input
- CYC_W, 16, width of `cycle_count` output

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; level-sensitive
- half_period  in  CNT_W  clocks per half-cycle (H)
- blank_cycles  in  BLANK_W  settling clocks after each edge (B)
- sample_div  in  DIV_W  clocks between sample requests inside the acquire window (D)
- switch_pwm  out  1  chopping drive; 1 = source on
- acq_window  out  1  high during settled (acquire) clocks
- sample_req  out  1  one-clock sample strobe
- sample_phase  out  1  phase of `sample_req`; 1 = on half, 0 = off half
- cycle_done  out  1  one-clock pulse on the last clock of each full cycle
- samples_per_half  out  DIV_W  requests issued per half for the current cycle's settings
- cycle_count  out  CYC_W  completed full cycles, wraps modulo 2^CYC_W
- busy  out  1  high whenever not in IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, the FSM enters IDLE and all counters clear. Reset applies immediately mid-cycle; `switch_pwm` drops on the next clock.
- FSM states: IDLE, ON_BLANK, ON_ACQ, OFF_BLANK, OFF_ACQ.
- Cycle start:
  - In IDLE with `enable`=1 at edge k, the block latches the config and enters ON_BLANK.
  - `switch_pwm`=1 and `busy`=1 from edge k+1.
- Config latch: H, B and D are captured only on entry to ON_BLANK (each full-cycle start). Input changes mid-cycle have no effect until the next cycle.
- Clamping at latch:
  - H<2 is treated as 2.
  - B>H-1 is treated as H-1, so the acquire window is always at least 1 clock.
  - D=0 is treated as 1.
- Each half lasts exactly H clocks:
  - BLANK for the first B clocks (skipped entirely if B=0), then ACQ for H-B clocks.
  - `switch_pwm`=1 throughout ON_*, 0 throughout OFF_* and IDLE.
  - `acq_window`=1 exactly in ON_ACQ and OFF_ACQ.
- Sample requests:
  - `sample_req` pulses at acquire-clock indices 0, D, 2D, ... below H-B.
  - The per-half count is N = ceil((H-B)/D), identical for both halves.
  - `sample_phase` equals `switch_pwm` on the same clock.
  - The sample-divider counter resets at every ACQ entry, so it never carries across halves.
- `samples_per_half` is updated to N one clock after the config latch and holds for the cycle.
- Cycle end:
  - `cycle_done` pulses on the final OFF_ACQ clock.
  - `cycle_count` increments on that same edge, wrapping from all-ones to 0.
- Transitions:
  - At the end of OFF_ACQ, if `enable`=1, go to ON_BLANK with a new latch and no idle gap; the period is exactly 2H.
  - Otherwise go to IDLE.
  - Deasserting `enable` mid-cycle never truncates a cycle; the block finishes OFF_ACQ first, so on/off sample counts stay matched.
- `sample_req` and `cycle_done` are asserted together on the final clock when (H-B-1) mod D == 0. Both are valid that clock, and the demodulator must accumulate the sample before closing.

Test Plan:
- Nominal: H=10, B=3, D=2, `enable` held -> `switch_pwm` 10 high / 10 low; `sample_req` at acquire indices 0, 2, 4, 6 (4 per half, phase 1 then 0); `samples_per_half`=4; `cycle_done` every 20 clocks; `cycle_count` 1, 2, 3.
- Mid-cycle disable: same config, drop `enable` at clock 5 of the first ON half -> cycle completes (20 clocks, 4+4 requests, one `cycle_done`), then IDLE with `switch_pwm`=0 and `busy`=0.
- Clamps: H=1, B=9, D=0 -> H=2, B=1, D=1; 1 blank + 1 acquire per half, 1 request per half, period 4.
- Config change mid-cycle: start H=8, B=2, D=3; change to H=4 at clock 3 -> current cycle keeps 8/8 with 2 requests per half; next cycle 4/4 with 1 request per half.
- Reset: assert `reset` during ON_ACQ -> next clock all outputs 0 and state IDLE; restart after release -> `cycle_count` restarts from 0.
- Wrap and coincident edge: CYC_W forced to 2, H=4, B=0, D=3, run 5 cycles -> `cycle_count` 1, 2, 3, 0, 1; `sample_req` and `cycle_done` coincide on the last OFF clock.
